// File: rtl/rp_row_sequencer.sv
// Repeated-pattern mask row sequencer: tiles one pattern row across the sensor width per sensor row.
// Optional RP_SEQ_SHADOW_CFG_EN: double-buffered config, promoted to active at frame start.
module rp_row_sequencer #(
    parameter int SENSOR_W = 300,
    parameter int SENSOR_H = 300
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clk_en,
    input  logic                i_cfg_valid,
    output logic                o_cfg_ready,
    input  logic [4:0]          i_cfg_pattern_w,
    input  logic [4:0]          i_cfg_pattern_h,
    input  logic [24:0]         i_cfg_pattern,
    output logic                o_cfg_err,
    input  logic                i_start,
    input  logic                i_abort,
    output logic                o_busy,
    output logic [SENSOR_W-1:0] o_row_data,
    output logic [10:0]         o_row_idx,
    output logic                o_row_valid,
    input  logic                i_row_ready,
    output logic                o_frame_done
);
    localparam int CW = $clog2(SENSOR_W + 32);

    typedef enum logic [1:0] {S_IDLE, S_GEN, S_OUT, S_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic [4:0]          r_st_w, r_st_h;
    logic [24:0]         r_st_pat;
    logic                r_st_loaded;
    logic                r_cfg_err;
    logic [SENSOR_W-1:0] r_row;
    logic [10:0]         r_row_cnt;
    logic [4:0]          r_prow;
    logic [CW-1:0]       r_col;

    logic [4:0]          w_w, w_h;
    logic [24:0]         w_pat;
    logic [9:0]          w_area;
    logic                w_cfg_ok, w_cfg_acc, w_cfg_store, w_start_go, w_abort;
    logic                w_accept, w_last_row, w_gen_last;
    logic [9:0]          w_prow_off;
    logic [24:0]         w_tmask, w_tile;
    logic [CW-1:0]       w_col_nxt;
    logic [SENSOR_W-1:0] w_ins, w_msk;
    logic [4:0]          w_prow_nxt;

    assign w_area      = 10'(i_cfg_pattern_w) * 10'(i_cfg_pattern_h);
    assign w_cfg_ok    = (i_cfg_pattern_w != 5'd0) && (i_cfg_pattern_h != 5'd0) && (w_area <= 10'd25);
    assign w_cfg_acc   = i_cfg_valid & o_cfg_ready;
    assign w_cfg_store = w_cfg_acc & w_cfg_ok;
    // A config accepted in the same cycle as start counts as loaded for that start.
    assign w_start_go  = (r_state == S_IDLE) & i_start & (r_st_loaded | w_cfg_store);
    assign w_abort     = i_abort & (r_state != S_IDLE);
    assign w_accept    = (r_state == S_OUT) & i_row_ready;
    assign w_last_row  = (r_row_cnt == 11'(SENSOR_H - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_st_w      <= 5'd1;
            r_st_h      <= 5'd1;
            r_st_pat    <= '0;
            r_st_loaded <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else if (i_clk_en) begin
            r_cfg_err <= w_cfg_acc & ~w_cfg_ok;
            if (w_cfg_store) begin
                r_st_w      <= i_cfg_pattern_w;
                r_st_h      <= i_cfg_pattern_h;
                r_st_pat    <= i_cfg_pattern;
                r_st_loaded <= 1'b1;
            end
        end
    end

`ifdef RP_SEQ_SHADOW_CFG_EN
    logic [4:0]  r_act_w, r_act_h;
    logic [24:0] r_act_pat;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act_w   <= 5'd1;
            r_act_h   <= 5'd1;
            r_act_pat <= '0;
        end else if (i_clk_en && w_start_go) begin
            r_act_w   <= w_cfg_store ? i_cfg_pattern_w : r_st_w;
            r_act_h   <= w_cfg_store ? i_cfg_pattern_h : r_st_h;
            r_act_pat <= w_cfg_store ? i_cfg_pattern   : r_st_pat;
        end
    end

    assign w_w   = r_act_w;
    assign w_h   = r_act_h;
    assign w_pat = r_act_pat;
`else
    assign w_w   = r_st_w;
    assign w_h   = r_st_h;
    assign w_pat = r_st_pat;
`endif

    // Tile = w bits of the current pattern row, placed at column offset r_col; bits past the edge fall off.
    assign w_prow_off = 10'(r_prow) * 10'(w_w);
    assign w_tmask    = 25'((26'd1 << w_w) - 26'd1);
    assign w_tile     = (w_pat >> w_prow_off) & w_tmask;
    assign w_ins      = SENSOR_W'(w_tile) << r_col;
    assign w_msk      = SENSOR_W'(w_tmask) << r_col;
    assign w_col_nxt  = r_col + CW'(w_w);
    assign w_gen_last = (w_col_nxt >= CW'(SENSOR_W));
    assign w_prow_nxt = (r_prow == w_h - 5'd1) ? 5'd0 : r_prow + 5'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row     <= '0;
            r_row_cnt <= '0;
            r_prow    <= '0;
            r_col     <= '0;
        end else if (i_clk_en && !w_abort) begin
            if (w_start_go) begin
                r_row_cnt <= '0;
                r_prow    <= '0;
                r_col     <= '0;
            end else if (r_state == S_GEN) begin
                r_row <= (r_row & ~w_msk) | w_ins;
                r_col <= w_col_nxt;
            end else if (w_accept && !w_last_row) begin
                r_row_cnt <= r_row_cnt + 11'd1;
                r_prow    <= w_prow_nxt;
                r_col     <= '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      r_state <= S_IDLE;
        else if (i_clk_en) r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start_go) w_state_nxt = S_GEN;
            S_GEN:  if (w_gen_last) w_state_nxt = S_OUT;
            S_OUT:  if (i_row_ready) w_state_nxt = w_last_row ? S_DONE : S_GEN;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_IDLE;
    end

    always_comb begin
        o_busy       = (r_state != S_IDLE);
        o_row_valid  = (r_state == S_OUT);
        o_frame_done = (r_state == S_DONE) & ~i_abort;
`ifdef RP_SEQ_SHADOW_CFG_EN
        o_cfg_ready  = 1'b1;
`else
        o_cfg_ready  = (r_state == S_IDLE);
`endif
    end

    assign o_cfg_err  = r_cfg_err;
    assign o_row_data = r_row;
    assign o_row_idx  = r_row_cnt;
endmodule
